instr_fetch_rv: RTL and testbench



---
 rtl/instr_fetch_rv.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_rv.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_rv.sv
// rtl/instr_fetch_rv.sv - RV32I instruction fetch and next-PC unit
//
// Owns the PC, fetches one word per round trip over a req/ready handshake,
// holds it for the decoder until retire, then computes the next PC.
// Illegal instructions and misaligned targets park the unit in FAULT.
//
// Ports:
//   iwClk, iwnRst                  clock, async active-low reset
//   owIMemReq/owIMemAddr           fetch request and word address
//   iwIMemReady/iwIMemData         fetch completion and returned word
//   owInstr/owOldPc/owPc           held instruction, its PC, PC + 4
//   owInstrValid                   instruction held, awaiting retire
//   iwRetire, iwnIllegal           retire strobe, legality (0 = illegal)
//   iwNextPcSrc                    0 SEQ, 1 JAL, 2 JALR, 3 B
//   iwNextPcImmediate20/12         raw immediate fields from the decoder
//   iwBranchInverted, iwAluResult  branch sense and compare result (bit 0)
//   iwReg1Data                     rs1 value for JALR
//   owFault/owFaultCause           sticky fault, 1 illegal / 2 misaligned
//   owRetireCount                  retired-instruction counter
module instr_fetch_rv #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  output logic        owIMemReq,
  output logic [31:0] owIMemAddr,
  input  logic        iwIMemReady,
  input  logic [31:0] iwIMemData,
  output logic [31:0] owInstr,
  output logic [31:0] owOldPc,
  output logic [31:0] owPc,
  output logic        owInstrValid,
  input  logic        iwRetire,
  input  logic        iwnIllegal,
  input  logic [1:0]  iwNextPcSrc,
  input  logic [19:0] iwNextPcImmediate20,
  input  logic [11:0] iwNextPcImmediate12,
  input  logic        iwBranchInverted,
  input  logic [31:0] iwAluResult,
  input  logic [31:0] iwReg1Data,
  output logic        owFault,
  output logic [1:0]  owFaultCause,
  output logic [31:0] owRetireCount
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] SRC_SEQ  = 2'd0;
  localparam logic [1:0] SRC_JAL  = 2'd1;
  localparam logic [1:0] SRC_JALR = 2'd2;
  localparam logic [1:0] SRC_B    = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] old_pc_q;
  logic [31:0] instr_q;
  logic [1:0]  cause_q;
  logic [31:0] count_q;

  logic [31:0] seq_pc;
  logic [31:0] jal_off;
  logic [31:0] br_off;
  logic        br_taken;
  logic [31:0] target_d;

  // Only the compare bit of the ALU result matters here.
  logic unused_alu_hi;
  assign unused_alu_hi = ^iwAluResult[31:1];

  assign seq_pc = old_pc_q + 32'd4;

  // The decoder hands over raw instruction fields; unscramble the J and B
  // immediates here so the decoder stays free of PC-specific packing.
  assign jal_off = {{11{iwNextPcImmediate20[19]}}, iwNextPcImmediate20[19],
                    iwNextPcImmediate20[7:0], iwNextPcImmediate20[8],
                    iwNextPcImmediate20[18:9], 1'b0};
  assign br_off  = {{19{iwNextPcImmediate12[11]}}, iwNextPcImmediate12[11],
                    iwNextPcImmediate12[0], iwNextPcImmediate12[10:5],
                    iwNextPcImmediate12[4:1], 1'b0};
  assign br_taken = iwAluResult[0] ^ iwBranchInverted;

  always_comb begin
    target_d = seq_pc;
    case (iwNextPcSrc)
      SRC_SEQ:  target_d = seq_pc;
      SRC_JAL:  target_d = old_pc_q + jal_off;
      SRC_JALR: target_d = (iwReg1Data + {{20{iwNextPcImmediate12[11]}},
                                          iwNextPcImmediate12}) & ~32'h1;
      SRC_B:    target_d = br_taken ? (old_pc_q + br_off) : seq_pc;
      default:  target_d = seq_pc;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
      instr_q  <= NOP;
      cause_q  <= 2'd0;
      count_q  <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (iwIMemReady) begin
            instr_q  <= iwIMemData;
            old_pc_q <= pc_q;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (iwRetire) begin
            if (!iwnIllegal) begin
              cause_q <= 2'd1;
              state_q <= S_FAULT;
            end else if (target_d[1:0] != 2'b00) begin
              cause_q <= 2'd2;
              state_q <= S_FAULT;
            end else begin
              pc_q    <= target_d;
              count_q <= count_q + 32'd1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_FAULT;
      endcase
    end
  end

  // Request is gated by reset so it drops the instant reset asserts.
  assign owIMemReq     = iwnRst && (state_q == S_FETCH);
  assign owIMemAddr    = pc_q;
  assign owInstr       = instr_q;
  assign owOldPc       = old_pc_q;
  assign owPc          = seq_pc;
  assign owInstrValid  = (state_q == S_EXEC);
  assign owFault       = (state_q == S_FAULT);
  assign owFaultCause  = cause_q;
  assign owRetireCount = count_q;

endmodule

// File: tb/tb_instr_fetch_rv.sv
// tb/tb_instr_fetch_rv.sv - directed self-checking bench for instr_fetch_rv
module tb_instr_fetch_rv;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] mdata;
  logic [31:0] instr;
  logic [31:0] oldpc;
  logic [31:0] pc;
  logic        ivalid;
  logic        retire;
  logic        nillegal;
  logic [1:0]  src;
  logic [19:0] imm20;
  logic [11:0] imm12;
  logic        binv;
  logic [31:0] alu;
  logic [31:0] rs1;
  logic        fault;
  logic [1:0]  cause;
  logic [31:0] count;

  int n_cmp;
  int n_fail;
  logic [31:0] exp_count;

  instr_fetch_rv #(.RESET_PC(32'h0000_0000)) dut (
    .iwClk(clk), .iwnRst(rst_n),
    .owIMemReq(req), .owIMemAddr(addr),
    .iwIMemReady(ready), .iwIMemData(mdata),
    .owInstr(instr), .owOldPc(oldpc), .owPc(pc), .owInstrValid(ivalid),
    .iwRetire(retire), .iwnIllegal(nillegal), .iwNextPcSrc(src),
    .iwNextPcImmediate20(imm20), .iwNextPcImmediate12(imm12),
    .iwBranchInverted(binv), .iwAluResult(alu), .iwReg1Data(rs1),
    .owFault(fault), .owFaultCause(cause), .owRetireCount(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: wait for a request, report its address and how many
  // falling edges it took, then complete it with zero wait.
  task automatic fetch_instr(input logic [31:0] data, output logic [31:0] a, output int waits);
    waits = -1;
    a = 32'hxxxx_xxxx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req === 1'b1) begin
        a = addr;
        waits = i;
        break;
      end
    end
    if (waits > 0) begin
      ready = 1'b1;
      mdata = data;
      @(posedge clk);
      #1 ready = 1'b0;
    end
  endtask

  task automatic do_retire(input logic [1:0] s, input logic [19:0] i20, input logic [11:0] i12,
                           input logic bi, input logic [31:0] al, input logic [31:0] r1,
                           input logic legal);
    @(negedge clk);
    src = s; imm20 = i20; imm12 = i12; binv = bi; alu = al; rs1 = r1; nillegal = legal;
    retire = 1'b1;
    @(posedge clk);
    #1 retire = 1'b0;
    nillegal = 1'b1;
    src = 2'd0; imm20 = 20'hABCDE; imm12 = 12'h555; rs1 = 32'h0BAD_0001; alu = 32'h0;
  endtask

  task automatic test_reset;
    logic [31:0] a;
    int w;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (req !== 1'b0) begin $display("FAIL rst_req got=%0b exp=0", req); n_fail++; end n_cmp++;
    if (instr !== 32'h13) begin $display("FAIL rst_instr got=%h exp=00000013", instr); n_fail++; end n_cmp++;
    if (ivalid !== 1'b0) begin $display("FAIL rst_valid got=%0b exp=0", ivalid); n_fail++; end n_cmp++;
    if (fault !== 1'b0 || cause !== 2'd0) begin $display("FAIL rst_fault got=%0b/%0d exp=0/0", fault, cause); n_fail++; end n_cmp++;
    if (count !== 32'd0) begin $display("FAIL rst_count got=%0d exp=0", count); n_fail++; end n_cmp++;
    if (oldpc !== 32'h0 || pc !== 32'h4) begin $display("FAIL rst_pcs got=%h/%h exp=0/4", oldpc, pc); n_fail++; end n_cmp++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = 0;
    fetch_instr(32'h0000_0013, a, w);
    if (w !== 1) begin $display("FAIL first_req_cycle got=%0d exp=1", w); n_fail++; end n_cmp++;
    if (a !== 32'h0) begin $display("FAIL first_req_addr got=%h exp=00000000", a); n_fail++; end n_cmp++;
    if (ivalid !== 1'b1 || instr !== 32'h13) begin $display("FAIL exec_entry got=%0b/%h exp=1/00000013", ivalid, instr); n_fail++; end n_cmp++;
    if (oldpc !== 32'h0 || pc !== 32'h4) begin $display("FAIL exec_pcs got=%h/%h exp=0/4", oldpc, pc); n_fail++; end n_cmp++;
    do_retire(2'd0, 20'h0, 12'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (req !== 1'b1 || addr !== 32'h4) begin $display("FAIL seq_next got=%0b/%h exp=1/00000004", req, addr); n_fail++; end n_cmp++;
    if (count !== exp_count) begin $display("FAIL seq_count got=%0d exp=%0d", count, exp_count); n_fail++; end n_cmp++;
  endtask

  task automatic test_jal;
    logic [31:0] a;
    int w;
    fetch_instr(32'h0000_0067, a, w);
    do_retire(2'd2, 20'h0, 12'h000, 1'b0, 32'h0, 32'h0000_0100, 1'b1);
    exp_count++;
    fetch_instr(32'h0080_006F, a, w);
    if (a !== 32'h100) begin $display("FAIL jal_setup got=%h exp=00000100", a); n_fail++; end n_cmp++;
    do_retire(2'd1, 20'h00800, 12'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (addr !== 32'h108) begin $display("FAIL jal_target got=%h exp=00000108", addr); n_fail++; end n_cmp++;
    if (count !== exp_count) begin $display("FAIL jal_count got=%0d exp=%0d", count, exp_count); n_fail++; end n_cmp++;
  endtask

  // s = 12'hFF1 packs the B offset -16 (13'h1FF0).
  task automatic test_branch;
    logic [31:0] a;
    int w;
    fetch_instr(32'h0000_0067, a, w);
    do_retire(2'd2, 20'h0, 12'h000, 1'b0, 32'h0, 32'h0000_0200, 1'b1);
    exp_count++;
    fetch_instr(32'hFE00_08E3, a, w);
    if (a !== 32'h200) begin $display("FAIL br_setup got=%h exp=00000200", a); n_fail++; end n_cmp++;
    do_retire(2'd3, 20'h0, 12'hFF1, 1'b0, 32'h1, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (addr !== 32'h1F0) begin $display("FAIL br_taken got=%h exp=000001f0", addr); n_fail++; end n_cmp++;
    fetch_instr(32'h0000_0067, a, w);
    do_retire(2'd2, 20'h0, 12'h000, 1'b0, 32'h0, 32'h0000_0200, 1'b1);
    exp_count++;
    fetch_instr(32'hFE00_08E3, a, w);
    do_retire(2'd3, 20'h0, 12'hFF1, 1'b1, 32'h1, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (addr !== 32'h204) begin $display("FAIL br_not_taken got=%h exp=00000204", addr); n_fail++; end n_cmp++;
    fetch_instr(32'hFE00_08E3, a, w);
    do_retire(2'd3, 20'h0, 12'hFF1, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (addr !== 32'h1F4) begin $display("FAIL br_inv_taken got=%h exp=000001f4", addr); n_fail++; end n_cmp++;
    if (count !== exp_count) begin $display("FAIL br_count got=%0d exp=%0d", count, exp_count); n_fail++; end n_cmp++;
  endtask

  task automatic test_stall_ignore;
    logic [31:0] a;
    int w;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      retire = (i % 2 == 0);
      if (req !== 1'b1 || addr !== 32'h1F4 || ivalid !== 1'b0)
        begin $display("FAIL stall_hold_%0d got=%0b/%h/%0b exp=1/000001f4/0", i, req, addr, ivalid); n_fail++; end
      n_cmp++;
    end
    @(posedge clk);
    #1 retire = 1'b0;
    fetch_instr(32'hABCD_0013, a, w);
    if (a !== 32'h1F4) begin $display("FAIL stall_addr got=%h exp=000001f4", a); n_fail++; end n_cmp++;
    @(negedge clk);
    ready = 1'b1;
    mdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 ready = 1'b0;
    if (instr !== 32'hABCD_0013 || ivalid !== 1'b1 || oldpc !== 32'h1F4)
      begin $display("FAIL exec_ready_ignored got=%h/%0b/%h exp=abcd0013/1/000001f4", instr, ivalid, oldpc); n_fail++; end
    n_cmp++;
    do_retire(2'd0, 20'h0, 12'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (addr !== 32'h1F8 || count !== exp_count)
      begin $display("FAIL stall_retire got=%h/%0d exp=000001f8/%0d", addr, count, exp_count); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    int w;
    fetch_instr(32'h0000_0067, a, w);
    do_retire(2'd2, 20'h0, 12'h000, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1);
    exp_count++;
    fetch_instr(32'h0000_0013, a, w);
    if (a !== 32'hFFFF_FFFC) begin $display("FAIL wrap_addr got=%h exp=fffffffc", a); n_fail++; end n_cmp++;
    if (pc !== 32'h0) begin $display("FAIL wrap_owpc got=%h exp=00000000", pc); n_fail++; end n_cmp++;
    do_retire(2'd0, 20'h0, 12'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_count++;
    @(negedge clk);
    if (addr !== 32'h0 || req !== 1'b1) begin $display("FAIL wrap_next got=%0b/%h exp=1/00000000", req, addr); n_fail++; end n_cmp++;
  endtask

  task automatic test_jalr_fault;
    logic [31:0] a;
    int w;
    fetch_instr(32'h0000_0067, a, w);
    do_retire(2'd2, 20'h0, 12'hFFF, 1'b0, 32'h0, 32'h0000_1001, 1'b1);
    exp_count++;
    fetch_instr(32'h0000_0067, a, w);
    if (a !== 32'h1000) begin $display("FAIL jalr_target got=%h exp=00001000", a); n_fail++; end n_cmp++;
    do_retire(2'd2, 20'h0, 12'h002, 1'b0, 32'h0, 32'h0000_1001, 1'b1);
    @(negedge clk);
    if (fault !== 1'b1 || cause !== 2'd2) begin $display("FAIL misalign_fault got=%0b/%0d exp=1/2", fault, cause); n_fail++; end n_cmp++;
    if (req !== 1'b0 || ivalid !== 1'b0) begin $display("FAIL misalign_req got=%0b/%0b exp=0/0", req, ivalid); n_fail++; end n_cmp++;
    if (count !== exp_count || addr !== 32'h1000)
      begin $display("FAIL misalign_state got=%0d/%h exp=%0d/00001000", count, addr, exp_count); n_fail++; end
    n_cmp++;
    ready = 1'b1;
    retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0; retire = 1'b0;
    if (fault !== 1'b1 || cause !== 2'd2 || req !== 1'b0 || count !== exp_count)
      begin $display("FAIL fault_sticky got=%0b/%0d/%0b/%0d exp=1/2/0/%0d", fault, cause, req, count, exp_count); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_illegal;
    logic [31:0] a;
    int w;
    rst_n = 1'b0;
    #1;
    if (fault !== 1'b0 || count !== 32'd0) begin $display("FAIL rst_from_fault got=%0b/%0d exp=0/0", fault, count); n_fail++; end n_cmp++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = 0;
    fetch_instr(32'hFFFF_FFFF, a, w);
    if (a !== 32'h0) begin $display("FAIL ill_addr got=%h exp=00000000", a); n_fail++; end n_cmp++;
    do_retire(2'd1, 20'h00800, 12'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    if (fault !== 1'b1 || cause !== 2'd1) begin $display("FAIL ill_fault got=%0b/%0d exp=1/1", fault, cause); n_fail++; end n_cmp++;
    if (req !== 1'b0 || addr !== 32'h0 || count !== 32'd0)
      begin $display("FAIL ill_state got=%0b/%h/%0d exp=0/00000000/0", req, addr, count); n_fail++; end
    n_cmp++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    if (fault !== 1'b0 || cause !== 2'd0 || req !== 1'b0)
      begin $display("FAIL async_clear got=%0b/%0d/%0b exp=0/0/0", fault, cause, req); n_fail++; end
    n_cmp++;
    if (instr !== 32'h13 || ivalid !== 1'b0) begin $display("FAIL async_instr got=%h/%0b exp=00000013/0", instr, ivalid); n_fail++; end n_cmp++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    fetch_instr(32'h0000_0013, a, w);
    if (w !== 1 || a !== 32'h0) begin $display("FAIL restart got=%0d/%h exp=1/00000000", w, a); n_fail++; end n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_count = 0;
    rst_n = 1'b0;
    ready = 1'b0;
    mdata = 32'h0;
    retire = 1'b0;
    nillegal = 1'b1;
    src = 2'd0;
    imm20 = 20'h0;
    imm12 = 12'h0;
    binv = 1'b0;
    alu = 32'h0;
    rs1 = 32'h0;
    test_reset();
    test_jal();
    test_branch();
    test_stall_ignore();
    test_wrap();
    test_jalr_fault();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
